// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// codes, the responder FSM state type and the byte-offset width helper.
package dmem_responder_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Number of byte-address bits that fall inside the memory.
   function automatic int addr_off_width(input int depth_words);
      return $clog2(depth_words * 4);
   endfunction

endpackage

// File: rtl/dmem_responder_mem_lane_align.sv
// Little-endian lane steering: store byte enables and replicated write data,
// load extraction with sign/zero extension, and a natural-alignment check.
module mem_lane_align
   import dmem_responder_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] wword,
   output logic [31:0] rdata_ext,
   output logic        misalign
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        sign;

   assign byte_sel = rword[{addr_lo, 3'b000} +: 8];
   assign half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
   assign sign     = ~funct3[2];

   always_comb begin
      be        = 4'b0000;
      wword     = wdata;
      rdata_ext = '0;
      misalign  = 1'b0;
      case (funct3)
         F3_B, F3_BU: begin
            be        = 4'b0001 << addr_lo;
            wword     = {4{wdata[7:0]}};
            rdata_ext = {{24{sign & byte_sel[7]}}, byte_sel};
         end
         F3_H, F3_HU: begin
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wword     = {2{wdata[15:0]}};
            rdata_ext = {{16{sign & half_sel[15]}}, half_sel};
            misalign  = addr_lo[0];
         end
         F3_W: begin
            be        = 4'b1111;
            rdata_ext = rword;
            misalign  = |addr_lo;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline load/store port with a fixed number
// of wait cycles, RV32I access sizes and fault reporting on a single response.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int WIDTH_DATA  = 32,
   parameter int WIDTH_ADDR  = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [WIDTH_ADDR-1:0] req_addr,
   input  logic [WIDTH_DATA-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WIDTH_DATA-1:0] rsp_rdata,
   output logic                  rsp_err
);

   localparam int OFF_W = addr_off_width(DEPTH_WORDS);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   // Handshakes: a transfer happens on an edge where valid & ready are both
   // high; valid and its payload hold until that edge, ready may not wait on valid.
   state_t                state, state_next;
   logic [CNT_W-1:0]      cnt;
   logic                  lat_we;
   logic [2:0]            lat_funct3;
   logic [WIDTH_ADDR-1:0] lat_addr;
   logic [WIDTH_DATA-1:0] lat_wdata;
   logic [WIDTH_DATA-1:0] mem [DEPTH_WORDS];

   logic [OFF_W-3:0]      word_idx;
   logic [3:0]            be;
   logic [31:0]           wword, rdata_ext;
   logic                  misalign, illegal, out_of_range, acc_err;
   logic                  do_access, wr_en;

   assign req_ready = (state == ST_IDLE) & ~rst;
   assign rsp_valid = (state == ST_RESP);
   assign word_idx  = lat_addr[OFF_W-1:2];

   mem_lane_align u_align (
      .funct3    (lat_funct3),
      .addr_lo   (lat_addr[1:0]),
      .rword     (mem[word_idx]),
      .wdata     (lat_wdata),
      .be        (be),
      .wword     (wword),
      .rdata_ext (rdata_ext),
      .misalign  (misalign)
   );

   generate
      if (OFF_W < WIDTH_ADDR) begin : g_range
         assign out_of_range = |lat_addr[WIDTH_ADDR-1:OFF_W];
      end else begin : g_no_range
         assign out_of_range = 1'b0;
      end
   endgenerate

   assign illegal = lat_we ? (lat_funct3 > F3_W)
                           : (lat_funct3 == 3'b011) || (lat_funct3 == 3'b110) ||
                             (lat_funct3 == 3'b111);
   assign acc_err = misalign | illegal | out_of_range;

   // A reset arriving on the final BUSY edge still wins over the access.
   assign do_access = (state == ST_BUSY) && (cnt == '0) && !rst;
   assign wr_en     = do_access & lat_we & ~acc_err;

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (req_valid && req_ready) state_next = ST_BUSY;
         ST_BUSY: if (cnt == '0) state_next = ST_RESP;
         ST_RESP: if (rsp_ready) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_next;
         if (state == ST_IDLE && req_valid) begin
            cnt <= CNT_W'(LATENCY - 1);
         end else if (state == ST_BUSY) begin
            if (cnt != '0) begin
               cnt <= cnt - CNT_W'(1);
            end else begin
               rsp_err   <= acc_err;
               rsp_rdata <= (lat_we || acc_err) ? '0 : rdata_ext;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (req_valid && req_ready) begin
         lat_we     <= req_we;
         lat_funct3 <= req_funct3;
         lat_addr   <= req_addr;
         lat_wdata  <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[word_idx][b*8 +: 8] <= wword[b*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: table of single accesses scored
// through an expected-response queue, plus back-pressure and reset-abort sequences.
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q[$];

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   dmem_responder #(
      .WIDTH_DATA(32), .WIDTH_ADDR(32), .DEPTH_WORDS(1024), .LATENCY(LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive a request until accepted; optionally score its expected response.
   task automatic send_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic push,
                           input logic [31:0] er, input logic ee);
      int n = 0;
      @(negedge clk);
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         check("req_accept_timeout", 32'(n), 32'd0);
         req_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 req_valid = 1'b0;
         if (push) exp_q.push_back({ee, er});
      end
   endtask

   // Wait for the response right after acceptance, check latency and payload.
   task automatic get_rsp(input string name);
      int n = 0;
      logic [32:0] e;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 50);
      check({name, "_latency"}, 32'(n), 32'(LAT + 1));
      if (exp_q.size() == 0) begin
         check({name, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({name, "_rdata"}, rsp_rdata, e[31:0]);
         check({name, "_err"}, 32'(rsp_err), 32'(e[32]));
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] er, input logic ee);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = er; v.exp_err = ee;
      vecs.push_back(v);
   endtask

   initial begin
      logic [31:0] held_rdata;
      logic        held_err;
      logic [32:0] e;
      int          n;

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

      add(1'b1, F3_W,   32'h10,       32'hDEADBEEF, 32'h0,        1'b0);
      add(1'b0, F3_W,   32'h10,       32'h0,        32'hDEADBEEF, 1'b0);
      add(1'b1, F3_B,   32'h11,       32'h80,       32'h0,        1'b0);
      add(1'b0, F3_B,   32'h11,       32'h0,        32'hFFFFFF80, 1'b0);
      add(1'b0, F3_BU,  32'h11,       32'h0,        32'h00000080, 1'b0);
      add(1'b0, F3_W,   32'h10,       32'h0,        32'hDEAD80EF, 1'b0);
      add(1'b1, F3_H,   32'h13,       32'h1234,     32'h0,        1'b1);
      add(1'b0, F3_W,   32'h10,       32'h0,        32'hDEAD80EF, 1'b0);
      add(1'b0, 3'b011, 32'h10,       32'h0,        32'h0,        1'b1);
      add(1'b0, F3_W,   32'h1000,     32'h0,        32'h0,        1'b1);
      add(1'b1, F3_W,   32'hFFC,      32'hCAFEF00D, 32'h0,        1'b0);
      add(1'b0, F3_W,   32'hFFC,      32'h0,        32'hCAFEF00D, 1'b0);
      add(1'b0, F3_H,   32'h12,       32'h0,        32'hFFFFDEAD, 1'b0);
      add(1'b0, F3_HU,  32'h12,       32'h0,        32'h0000DEAD, 1'b0);
      add(1'b0, F3_B,   32'h13,       32'h0,        32'hFFFFFFDE, 1'b0);
      add(1'b1, F3_H,   32'h16,       32'h8001,     32'h0,        1'b0);
      add(1'b0, F3_H,   32'h16,       32'h0,        32'hFFFF8001, 1'b0);
      add(1'b0, F3_H,   32'h11,       32'h0,        32'h0,        1'b1);
      add(1'b1, F3_W,   32'h12,       32'h55555555, 32'h0,        1'b1);
      add(1'b1, 3'b011, 32'h10,       32'h55555555, 32'h0,        1'b1);
      add(1'b1, F3_W,   32'h80000010, 32'h55555555, 32'h0,        1'b1);
      add(1'b0, F3_W,   32'h10,       32'h0,        32'hDEAD80EF, 1'b0);

      // Reset state while rst is asserted.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_req_ready", 32'(req_ready), 32'd0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_rdata", rsp_rdata, 32'd0);
      check("reset_rsp_err", 32'(rsp_err), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_req_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         send_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 1'b1,
                  vecs[i].exp_rdata, vecs[i].exp_err);
         get_rsp($sformatf("v%0d", i));
      end

      // Back-pressure: response held, concurrent request must be ignored.
      send_req(1'b0, F3_W, 32'h10, 32'h0, 1'b1, 32'hDEAD80EF, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 50);
      check("bp_latency", 32'(n), 32'(LAT + 1));
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
      check("bp_rdata", rsp_rdata, e[31:0]);
      check("bp_err", 32'(rsp_err), 32'(e[32]));
      held_rdata = rsp_rdata;
      held_err   = rsp_err;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 1) begin
            req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h10; req_wdata = 32'h0;
            req_valid = 1'b1;
         end
         if (i == 3) req_valid = 1'b0;
         check($sformatf("bp_hold%0d_valid", i), 32'(rsp_valid), 32'd1);
         check($sformatf("bp_hold%0d_rdata", i), rsp_rdata, held_rdata);
         check($sformatf("bp_hold%0d_err", i), 32'(rsp_err), 32'(held_err));
         check($sformatf("bp_hold%0d_req_ready", i), 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      check("bp_after_req_ready", 32'(req_ready), 32'd1);
      check("bp_after_rsp_valid", 32'(rsp_valid), 32'd0);
      send_req(1'b0, F3_W, 32'h10, 32'h0, 1'b1, 32'hDEAD80EF, 1'b0);
      get_rsp("bp_no_second_write");

      // Reset during BUSY aborts the store and suppresses its response.
      send_req(1'b1, F3_W, 32'h20, 32'h11111111, 1'b1, 32'h0, 1'b0);
      get_rsp("abort_pre_store");
      send_req(1'b1, F3_W, 32'h20, 32'h22222222, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_req_ready_in_rst", 32'(req_ready), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("abort_no_rsp%0d", i), 32'(rsp_valid), 32'd0);
      end
      check("abort_req_ready", 32'(req_ready), 32'd1);
      send_req(1'b0, F3_W, 32'h20, 32'h0, 1'b1, 32'h11111111, 1'b0);
      get_rsp("abort_readback");

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
